// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents:
//   md_op_e    - operation encoding driven by the control unit
//   md_state_e - sequencer states (IDLE, RUN, FIX)
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_step.sv
// Combinational single-iteration datapath for the multiply/divide unit.
// Ports:
//   is_div  - 1: restoring divide step, 0: shift-add multiply step
//   acc     - current {HI, LO} accumulator
//   operand - multiplicand (multiply) or divisor (divide) magnitude
//   acc_nx  - accumulator after one radix-2 step
module mult_div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_nx
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] trial_s;
    logic             ge_s;

    // One radix-2 multiply or divide iteration.
    always_comb begin
        acc_nx  = acc;
        // Multiply: the carry out of the add is kept so it shifts into HI.
        sum_s   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // Divide: the partial remainder shifted left is WIDTH+1 bits wide,
        // so the trial compare is done on WIDTH+1 bits; only the low WIDTH
        // bits of the difference can be nonzero when the trial succeeds.
        ge_s    = (acc[2*WIDTH-1:WIDTH-1] >= {1'b0, operand});
        trial_s = acc[2*WIDTH-2:WIDTH-1] - operand;
        if (is_div) begin
            if (ge_s) begin
                acc_nx = {trial_s, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_nx = {sum_s, acc[WIDTH-1:1]};
            end else begin
                acc_nx = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start, op, a, b - launch request (sampled in IDLE), operation, operands
//   kill            - abort the in-flight operation without touching HI/LO
//   wr_hi, wr_lo    - mthi/mtlo strobes (honoured in IDLE), wr_data payload
//   hi, lo          - HI/LO registers
//   busy            - operation in flight (state != IDLE)
//   done            - one-cycle pulse after HI/LO were written by an operation
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    md_state_e          state_r, state_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nx_s;
    logic [WIDTH-1:0]   opnd_r;
    logic               is_div_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r;

    logic               launch_s;
    logic               is_signed_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

    assign launch_s    = (state_r == IDLE) && start && !kill;
    assign is_signed_s = (op == MD_MULT) || (op == MD_DIV);
    assign a_abs_s     = (is_signed_s && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    assign b_abs_s     = (is_signed_s && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

    mult_div_unit_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_r),
        .acc     (acc_r),
        .operand (opnd_r),
        .acc_nx  (acc_nx_s)
    );

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_neg_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
        fix_hi_s   = acc_r[2*WIDTH-1:WIDTH];
        fix_lo_s   = acc_r[WIDTH-1:0];
        if (is_div_r) begin
            // Quotient and remainder take independent signs.
            if (neg_hi_r) begin
                fix_hi_s = ~acc_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
            if (neg_lo_r) begin
                fix_lo_s = ~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                fix_lo_s = acc_r[WIDTH-1:0];
            end
        end else begin
            // The product is negated as one double-width value.
            if (neg_lo_r) begin
                fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
                fix_lo_s = prod_neg_s[WIDTH-1:0];
            end else begin
                fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
                fix_lo_s = acc_r[WIDTH-1:0];
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (kill) begin
                    state_nx = IDLE;
                end else if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nx = FIX;
                end else begin
                    state_nx = RUN;
                end
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers, HI/LO and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nx != IDLE);
            case (state_r)
                IDLE: begin
                    if (wr_hi) hi_r <= wr_data;
                    if (wr_lo) lo_r <= wr_data;
                    if (launch_s) begin
                        is_div_r <= op[1];
                        cnt_r    <= CNT_W'(WIDTH);
                        // Multiply keeps the multiplier in LO and shifts it
                        // out; divide keeps the dividend in LO and shifts in
                        // quotient bits.
                        acc_r    <= {{WIDTH{1'b0}}, op[1] ? a_abs_s : b_abs_s};
                        opnd_r   <= op[1] ? b_abs_s : a_abs_s;
                        neg_lo_r <= is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_r <= is_signed_s && a[WIDTH-1];
                    end
                end
                RUN: begin
                    if (!kill) begin
                        acc_r <= acc_nx_s;
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    if (!kill) begin
                        hi_r   <= fix_hi_s;
                        lo_r   <= fix_lo_s;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        kill;
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int bc, dc;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .kill    (kill),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns just after the launching edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles and done pulses until the operation ends.
    // At busy cycle number inj a stray start and mtlo are injected.
    task automatic finish_op(input int inj, output int busy_cnt, output int done_cnt);
        busy_cnt = busy ? 1 : 0;
        done_cnt = done ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            wr_lo = 1'b0;
            if (done) done_cnt++;
            if (!busy) break;
            busy_cnt++;
            if (busy_cnt == inj) begin
                start = 1'b1; op = 2'b11; a = 32'h0000_0064; b = 32'h0000_0003;
                wr_lo = 1'b1; wr_data = 32'h1234_5678;
            end
        end
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        int bcl, dcl;
        launch(o, av, bv);
        finish_op(-1, bcl, dcl);
        check_eq({tag, "_busy_cycles"}, 64'(bcl), 64'd33);
        check_eq({tag, "_done_pulses"}, 64'(dcl), 64'd1);
        check_eq({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
        check_eq({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        kill = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'h0;
        #12;
        check_eq("rst_hi", {32'h0, hi}, 64'h0);
        check_eq("rst_lo", {32'h0, lo}, 64'h0);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_done", {63'h0, done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_7_m3",  2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0",   2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_by0_neg",2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001);

        // mtlo / mthi in IDLE
        @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'h5555_AAAA;
        @(negedge clk);
        wr_lo = 1'b0;
        check_eq("mtlo", {32'h0, lo}, {32'h0, 32'h5555_AAAA});
        wr_hi = 1'b1; wr_data = 32'hAAAA_5555;
        @(negedge clk);
        wr_hi = 1'b0;
        check_eq("mthi", {32'h0, hi}, {32'h0, 32'hAAAA_5555});

        // Kill at busy cycle 10 of mult 3*4
        dc = 0;
        launch(2'b00, 32'h3, 32'h4);
        repeat (9) begin
            @(negedge clk);
            if (done) dc++;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_eq("kill_busy_drop", {63'h0, busy}, 64'h0);
        repeat (40) begin
            @(negedge clk);
            if (done) dc++;
        end
        check_eq("kill_no_done", 64'(dc), 64'd0);
        check_eq("kill_hi", {32'h0, hi}, {32'h0, 32'hAAAA_5555});
        check_eq("kill_lo", {32'h0, lo}, {32'h0, 32'h5555_AAAA});

        // Start together with kill in IDLE is ignored
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 2'b01; a = 32'h2; b = 32'h2;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check_eq("start_kill_idle", {63'h0, busy}, 64'h0);

        // Stray start and mtlo in flight are ignored
        launch(2'b01, 32'h0001_0000, 32'h0001_0000);
        finish_op(5, bc, dc);
        check_eq("stray_busy_cycles", 64'(bc), 64'd33);
        check_eq("stray_done_pulses", 64'(dc), 64'd1);
        check_eq("stray_hi", {32'h0, hi}, {32'h0, 32'h0000_0001});
        check_eq("stray_lo", {32'h0, lo}, {32'h0, 32'h0000_0000});
        check_eq("stray_idle_after", {63'h0, busy}, 64'h0);

        // Asynchronous reset in the middle of a divide
        launch(2'b10, 32'h0000_0064, 32'h0000_0007);
        repeat (19) @(negedge clk);
        check_eq("pre_rst_busy", {63'h0, busy}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_hi", {32'h0, hi}, 64'h0);
        check_eq("midrst_lo", {32'h0, lo}, 64'h0);
        check_eq("midrst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", {63'h0, busy}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the control unit.
- Executes mult/multu/div/divu decoded by the control unit and owns the HI/LO registers.
- HI/LO are read by mfhi/mflo and written by mthi/mtlo.
- Busy feeds the hazard unit, which stalls any dependent instruction until the operation completes.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  launch operation; sampled only in IDLE
- Op  in  2  00 mult, 01 multu, 10 div, 11 divu
- A  in  WIDTH  rs operand (multiplicand/dividend)
- B  in  WIDTH  rt operand (multiplier/divisor)
- Kill  in  1  abort in-flight operation (pipeline flush of owning instruction)
- WrHi  in  1  mthi write strobe
- WrLo  in  1  mtlo write strobe
- WrData  in  WIDTH  mthi/mtlo data
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Busy  out  1  operation in flight
- Done  out  1  one-cycle pulse: HI/LO just updated by an operation

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; Hi=0, Lo=0; Busy=0, Done=0; internal counter/accumulators=0.
  - Reset mid-operation discards the operation.
- States:
  - IDLE -> RUN when Start=1 at edge k. Latch Op, |A|, |B| (magnitudes for signed ops), and result-sign flags. Counter=WIDTH.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add.
    - Divide: restoring (33-bit trial subtract).
    - Counter decrements each step; at counter=1 -> FIX.
  - FIX, edge k+WIDTH+1: apply sign correction, write Hi/Lo, -> IDLE, Done=1 for the following cycle.
- Latency and outputs:
  - Busy=1 for exactly WIDTH+1 cycles (33 by default), from after edge k until edge k+33.
  - Busy is registered, i.e. state!=IDLE.
- Sign rules:
  - Signed mult: product negated when A[31]^B[31].
  - Signed div: quotient negated when A[31]^B[31]; remainder takes the sign of A.
  - Hi=upper product / remainder; Lo=lower product / quotient.
- Divide by zero (B=0): completes with normal latency, no exception.
  - divu: Lo=FFFFFFFF, Hi=A.
  - div: the same magnitude result, then sign-corrected per the sign rules.
- Overflow: div 80000000 / FFFFFFFF -> Lo=80000000, Hi=00000000; no trap.
- Start while Busy: ignored, no queueing; the hazard unit guarantees it does not occur.
- Kill:
  - Kill=1 in RUN or FIX -> IDLE at the next edge; Hi/Lo unchanged; no Done.
  - Kill in IDLE has no effect.
  - Kill and Start together in IDLE: Start is ignored.
- WrHi/WrLo:
  - Honoured only in IDLE; the register is updated at the edge.
  - Ignored while Busy.
  - Same-edge WrHi/WrLo and Start in IDLE: the write takes effect; the launched operation later overwrites Hi/Lo.
- Hi/Lo hold their values between updates. Read paths (mfhi/mflo) are combinational from the Hi/Lo outputs.

Decomposition:
- Shared header with the existing opcode/funct definitions:
  - Op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State encodings: IDLE, RUN, FIX.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: mode, accumulator, operand.
  - Output: next {Hi, Lo} accumulator.
  - Keeps the FSM file free of arithmetic.

Test Plan:
1. mult, A=00000007, B=FFFFFFFD -> Busy high 33 cycles; then Hi=FFFFFFFF, Lo=FFFFFFEB; Done pulses once.
2. multu, A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001. Then div, A=FFFFFFF9, B=00000002 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
3. divu, A=12345678, B=0 -> Lo=FFFFFFFF, Hi=12345678. Then div, A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=0.
4. WrHi with WrData=AAAA5555, then mult 3*4 started; Kill at cycle 10 -> Busy drops next cycle; Hi=AAAA5555, Lo unchanged; Done never asserted.
5. Second Start and WrLo driven mid-operation -> both ignored; final result matches the first operation only. Reset=0 at cycle 20 of a div -> Hi=Lo=0, Busy=0 immediately.
